// File: rtl/vdp_reg_ifce.sv
// VDP control-port register interface: two-byte writes either load R0-R7 or set
// up the VRAM address; a status-port read re-arms the byte pairing.
module vdp_reg_ifce (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_tick,
  input  logic        rd_tick,
  input  logic [7:0]  din,
  output logic [7:0]  reg0,
  output logic [7:0]  reg1,
  output logic [7:0]  reg2,
  output logic [7:0]  reg3,
  output logic [7:0]  reg4,
  output logic [7:0]  reg5,
  output logic [7:0]  reg6,
  output logic [7:0]  reg7,
  output logic [13:0] vram_addr,
  output logic        vram_wr_mode
);

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [7:0]        data_q, data_d;
  logic [7:0][7:0]   regs_q, regs_d;
  logic [13:0]       vram_addr_q, vram_addr_d;
  logic              vram_wr_mode_q, vram_wr_mode_d;

  logic wr_valid;
  assign wr_valid = wr_tick && !rd_tick;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_q <= PH_FIRST;
    else        phase_q <= phase_d;
  end

  // Next-state logic; a status read always re-arms and overrides a write.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    phase_d = phase_q;
    if (rd_tick) begin
      phase_d = PH_FIRST;
    end else if (wr_tick) begin
      phase_d = (phase_q == PH_FIRST) ? PH_SECOND : PH_FIRST;
    end
  end

  // Output/datapath logic driven by the current phase.
  always_comb begin
    data_d         = data_q;
    regs_d         = regs_q;
    vram_addr_d    = vram_addr_q;
    vram_wr_mode_d = vram_wr_mode_q;
    if (wr_valid) begin
      if (phase_q == PH_FIRST) begin
        data_d = din;
      end else if (din[7]) begin
        regs_d[din[2:0]] = data_q;
      end else begin
        vram_addr_d    = {din[5:0], data_q};
        vram_wr_mode_d = din[6];
      end
    end
  end

  // NOTE: the register file is cleared by reset because software may read
  // R0-R7 before programming them; it is small enough to be plain flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q         <= '0;
      regs_q         <= '0;
      vram_addr_q    <= '0;
      vram_wr_mode_q <= 1'b0;
    end else begin
      data_q         <= data_d;
      regs_q         <= regs_d;
      vram_addr_q    <= vram_addr_d;
      vram_wr_mode_q <= vram_wr_mode_d;
    end
  end

  assign reg0         = regs_q[0];
  assign reg1         = regs_q[1];
  assign reg2         = regs_q[2];
  assign reg3         = regs_q[3];
  assign reg4         = regs_q[4];
  assign reg5         = regs_q[5];
  assign reg6         = regs_q[6];
  assign reg7         = regs_q[7];
  assign vram_addr    = vram_addr_q;
  assign vram_wr_mode = vram_wr_mode_q;

endmodule

// File: tb/tb_vdp_reg_ifce.sv
// Directed bench for vdp_reg_ifce: hand-computed register/VRAM expectations,
// inputs driven and outputs sampled on the falling clock edge.
module tb_vdp_reg_ifce;

  logic        clk;
  logic        reset;
  logic        wr_tick;
  logic        rd_tick;
  logic [7:0]  din;
  logic [7:0]  reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [13:0] vram_addr;
  logic        vram_wr_mode;

  logic [7:0]  regs_obs [8];
  logic [7:0]  exp_regs [8];

  int n_tests = 0;
  int n_fail  = 0;

  vdp_reg_ifce dut (
    .clk          (clk),
    .reset        (reset),
    .wr_tick      (wr_tick),
    .rd_tick      (rd_tick),
    .din          (din),
    .reg0         (reg0),
    .reg1         (reg1),
    .reg2         (reg2),
    .reg3         (reg3),
    .reg4         (reg4),
    .reg5         (reg5),
    .reg6         (reg6),
    .reg7         (reg7),
    .vram_addr    (vram_addr),
    .vram_wr_mode (vram_wr_mode)
  );

  assign regs_obs[0] = reg0;
  assign regs_obs[1] = reg1;
  assign regs_obs[2] = reg2;
  assign regs_obs[3] = reg3;
  assign regs_obs[4] = reg4;
  assign regs_obs[5] = reg5;
  assign regs_obs[6] = reg6;
  assign regs_obs[7] = reg7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; returns on the next falling edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr_tick = w;
    rd_tick = r;
    din     = d;
    @(negedge clk);
    wr_tick = 1'b0;
    rd_tick = 1'b0;
    din     = 8'h00;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_reg%0d", tag, i), {24'h0, regs_obs[i]}, {24'h0, exp_regs[i]});
  endtask

  task automatic check_vram(input string tag, input logic [13:0] addr, input logic mode);
    check({tag, "_addr"}, {18'h0, vram_addr}, {18'h0, addr});
    check({tag, "_mode"}, {31'h0, vram_wr_mode}, {31'h0, mode});
  endtask

  initial begin
    reset   = 1'b0;
    wr_tick = 1'b0;
    rd_tick = 1'b0;
    din     = 8'h00;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;

    @(negedge clk);
    @(negedge clk);
    check_regs("reset");
    check_vram("reset", 14'h0000, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Basic write to R0, with the 1-cycle latency visible after the data byte.
    step(1'b1, 1'b0, 8'hEE);
    check("r0_after_data", {24'h0, reg0}, 32'h00);
    step(1'b1, 1'b0, 8'h80);
    exp_regs[0] = 8'hEE;
    check_regs("r0");

    // R3, then back-to-back writes with wr_tick held high.
    step(1'b1, 1'b0, 8'h33);
    step(1'b1, 1'b0, 8'h83);
    exp_regs[3] = 8'h33;
    check("r3", {24'h0, reg3}, 32'h33);
    step(1'b1, 1'b0, 8'h44);
    step(1'b1, 1'b0, 8'h84);
    step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'h85);
    step(1'b1, 1'b0, 8'h66);
    step(1'b1, 1'b0, 8'h86);
    exp_regs[4] = 8'h44;
    exp_regs[5] = 8'h55;
    exp_regs[6] = 8'h66;
    check_regs("burst");

    // Read mid-pair discards the pending byte; the next byte re-latches.
    step(1'b1, 1'b0, 8'h22);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h81);
    exp_regs[1] = 8'h11;
    check_regs("rd_rearm");

    // Rewrite R6; a read in FIRST leaves the pairing untouched.
    step(1'b1, 1'b0, 8'hF6);
    step(1'b1, 1'b0, 8'h86);
    exp_regs[6] = 8'hF6;
    check("r6_rewrite", {24'h0, reg6}, 32'hF6);
    step(1'b0, 1'b1, 8'h00);
    check_regs("rd_first");
    step(1'b1, 1'b0, 8'hAB);
    step(1'b1, 1'b0, 8'h85);
    exp_regs[5] = 8'hAB;
    check("rd_first_pair", {24'h0, reg5}, 32'hAB);

    // Idle gap between data and command bytes.
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h87);
    exp_regs[7] = 8'h77;
    check("r7_gap", {24'h0, reg7}, 32'h77);

    // Command bits 6:3 are ignored for register writes.
    step(1'b1, 1'b0, 8'h3C);
    step(1'b1, 1'b0, 8'hFB);
    exp_regs[3] = 8'h3C;
    check_regs("ign_bits");

    // VRAM address setup for write, then for read.
    step(1'b1, 1'b0, 8'h34);
    step(1'b1, 1'b0, 8'h52);
    check_vram("vram_wr", 14'h1234, 1'b1);
    check_regs("vram_wr_regs");
    step(1'b1, 1'b0, 8'h56);
    step(1'b1, 1'b0, 8'h0A);
    check_vram("vram_rd", 14'h0A56, 1'b0);

    // Simultaneous write and read in SECOND: read wins, write dropped.
    step(1'b1, 1'b0, 8'h9C);
    step(1'b1, 1'b1, 8'h81);
    check_regs("wr_rd_same");
    check_vram("wr_rd_same", 14'h0A56, 1'b0);
    step(1'b1, 1'b0, 8'h99);
    step(1'b1, 1'b0, 8'h82);
    exp_regs[2] = 8'h99;
    check("wr_rd_rearm", {24'h0, reg2}, 32'h99);

    // Asynchronous reset with a data byte pending.
    step(1'b1, 1'b0, 8'h5A);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    check_regs("async_rst");
    check_vram("async_rst", 14'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 8'hC3);
    step(1'b1, 1'b0, 8'h82);
    exp_regs[2] = 8'hC3;
    check_regs("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
